// File: rtl/reg_wb_unit.sv
// reg_wb_unit: write-back FIFO feeding the regfile write port, with pending-write lookup.
// Define WB_BYPASS_EN to build the forwarded-data mux; otherwise fwd_data1/2 read as 0.
module reg_wb_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0] in_data,
  input  logic              wb_stall,
  output logic [ADDR_W-1:0] writeREG,
  output logic [DATA_W-1:0] writeDATA,
  output logic              writeCTRL,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              pend1,
  output logic              pend2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2,
  output logic              idle
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fifo_reg_q  [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wctrl_q, wctrl_d;
  logic              push, pop, full, empty;
  logic [PTR_W-1:0]  idx;
  logic              lk_pend1, lk_pend2;
`ifdef WB_BYPASS_EN
  logic [DATA_W-1:0] lk_data1, lk_data2;
`endif

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  // Push is blocked whenever full, even if a pop frees a slot on the same edge.
  assign push     = in_valid && !full;
  assign pop      = !empty && !wb_stall;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    wctrl_d = pop;
    if (push) tail_d = tail_q + PTR_W'(1);
    if (pop) begin
      head_d  = head_q + PTR_W'(1);
      wreg_d  = fifo_reg_q[head_q];
      wdata_d = fifo_data_q[head_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      wreg_q  <= '0;
      wdata_q <= '0;
      wctrl_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      wctrl_q <= wctrl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg_q[tail_q]  <= in_reg;
      fifo_data_q[tail_q] <= in_data;
    end
  end

  // Scan oldest to youngest so the last match (tail-most FIFO entry) wins.
  always_comb begin
    lk_pend1 = 1'b0;
    lk_pend2 = 1'b0;
    idx      = '0;
`ifdef WB_BYPASS_EN
    lk_data1 = '0;
    lk_data2 = '0;
`endif
    if (wctrl_q && (wreg_q == rd_addr1)) begin
      lk_pend1 = 1'b1;
`ifdef WB_BYPASS_EN
      lk_data1 = wdata_q;
`endif
    end
    if (wctrl_q && (wreg_q == rd_addr2)) begin
      lk_pend2 = 1'b1;
`ifdef WB_BYPASS_EN
      lk_data2 = wdata_q;
`endif
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if (fifo_reg_q[idx] == rd_addr1) begin
          lk_pend1 = 1'b1;
`ifdef WB_BYPASS_EN
          lk_data1 = fifo_data_q[idx];
`endif
        end
        if (fifo_reg_q[idx] == rd_addr2) begin
          lk_pend2 = 1'b1;
`ifdef WB_BYPASS_EN
          lk_data2 = fifo_data_q[idx];
`endif
        end
      end
    end
  end

  assign pend1     = lk_pend1;
  assign pend2     = lk_pend2;
`ifdef WB_BYPASS_EN
  assign fwd_data1 = lk_data1;
  assign fwd_data2 = lk_data2;
`else
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
`endif

  assign writeREG  = wreg_q;
  assign writeDATA = wdata_q;
  assign writeCTRL = wctrl_q;
  assign idle      = empty && !wctrl_q;

endmodule

// File: tb/tb_reg_wb_unit.sv
// tb_reg_wb_unit: directed vector table plus hand sequences for stall, reset and streaming.
module tb_reg_wb_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, wb_stall = 1'b0;
  logic       in_ready;
  logic [2:0] in_reg = '0, rd_addr1 = '0, rd_addr2 = '0;
  logic [7:0] in_data = '0;
  logic [2:0] writeREG;
  logic [7:0] writeDATA;
  logic       writeCTRL, pend1, pend2, idle;
  logic [7:0] fwd_data1, fwd_data2;

  int checks = 0;
  int errors = 0;
  int k, w;
  logic acc;
  logic [7:0] rf [8];

  reg_wb_unit #(.DATA_W(8), .ADDR_W(3), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .wb_stall(wb_stall),
    .writeREG(writeREG), .writeDATA(writeDATA), .writeCTRL(writeCTRL),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .pend1(pend1), .pend2(pend2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .idle(idle)
  );

  always #5 clk = ~clk;

  // Regfile model: samples the write port at negedge.
  always @(negedge clk) if (writeCTRL) rf[writeREG] <= writeDATA;

  typedef struct {
    logic iv; logic [2:0] ireg; logic [7:0] idat; logic st;
    logic [2:0] r1; logic [2:0] r2;
    logic rdy; logic idl; logic p1; logic p2; logic [7:0] f1; logic [7:0] f2;
    logic wc; logic [2:0] wr; logic [7:0] wd;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_fwd(input logic [7:0] v);
`ifdef WB_BYPASS_EN
    return v;
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic [7:0] item_data(input int n);
    return 8'(n * 13 + 1);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    //           iv ireg idat  st r1 r2 rdy idl p1 p2 f1     f2     wc wr wd
    vecs[0]  = '{0, 0, 8'h00, 0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00};
    vecs[1]  = '{1, 3, 8'hA5, 0, 3, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00};
    vecs[2]  = '{0, 0, 8'h00, 0, 3, 4, 1, 0, 1, 0, 8'hA5, 8'h00, 1, 3, 8'hA5};
    vecs[3]  = '{0, 0, 8'h00, 0, 3, 3, 1, 0, 1, 1, 8'hA5, 8'hA5, 0, 3, 8'hA5};
    vecs[4]  = '{0, 0, 8'h00, 0, 3, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0, 3, 8'hA5};
    vecs[5]  = '{1, 1, 8'h11, 1, 1, 2, 1, 1, 0, 0, 8'h00, 8'h00, 0, 3, 8'hA5};
    vecs[6]  = '{1, 2, 8'h22, 1, 1, 2, 1, 0, 1, 0, 8'h11, 8'h00, 0, 3, 8'hA5};
    vecs[7]  = '{1, 4, 8'h44, 1, 4, 2, 0, 0, 0, 1, 8'h00, 8'h22, 0, 3, 8'hA5};
    vecs[8]  = '{0, 0, 8'h00, 0, 1, 4, 0, 0, 1, 0, 8'h11, 8'h00, 1, 1, 8'h11};
    vecs[9]  = '{0, 0, 8'h00, 0, 1, 2, 1, 0, 1, 1, 8'h11, 8'h22, 1, 2, 8'h22};
    vecs[10] = '{0, 0, 8'h00, 0, 4, 2, 1, 0, 0, 1, 8'h00, 8'h22, 0, 2, 8'h22};
    vecs[11] = '{0, 0, 8'h00, 0, 4, 2, 1, 1, 0, 0, 8'h00, 8'h00, 0, 2, 8'h22};
    vecs[12] = '{1, 5, 8'h10, 1, 5, 6, 1, 1, 0, 0, 8'h00, 8'h00, 0, 2, 8'h22};
    vecs[13] = '{1, 5, 8'h20, 1, 5, 6, 1, 0, 1, 0, 8'h10, 8'h00, 0, 2, 8'h22};
    vecs[14] = '{0, 0, 8'h00, 1, 5, 6, 0, 0, 1, 0, 8'h20, 8'h00, 0, 2, 8'h22};
    vecs[15] = '{0, 0, 8'h00, 0, 5, 6, 0, 0, 1, 0, 8'h20, 8'h00, 1, 5, 8'h10};
    vecs[16] = '{0, 0, 8'h00, 0, 5, 5, 1, 0, 1, 1, 8'h20, 8'h20, 1, 5, 8'h20};
    vecs[17] = '{0, 0, 8'h00, 0, 5, 2, 1, 0, 1, 0, 8'h20, 8'h00, 0, 5, 8'h20};
    vecs[18] = '{0, 0, 8'h00, 0, 5, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0, 5, 8'h20};

    for (int i = 0; i < 8; i++) rf[i] = 8'h00;

    // Reset then idle for three cycles.
    #12 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("rst_wctrl", writeCTRL, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_idle", idle, 1);
      chk("rst_pend1", pend1, 0);
      chk("rst_pend2", pend2, 0);
    end
    chk("rst_wreg", writeREG, 0);
    chk("rst_wdata", writeDATA, 0);

    // Vector table: comb outputs before the edge, registered outputs after it.
    for (int i = 0; i < 19; i++) begin
      in_valid = vecs[i].iv; in_reg = vecs[i].ireg; in_data = vecs[i].idat;
      wb_stall = vecs[i].st; rd_addr1 = vecs[i].r1; rd_addr2 = vecs[i].r2;
      #1;
      chk($sformatf("v%0d_ready", i), in_ready, vecs[i].rdy);
      chk($sformatf("v%0d_idle", i), idle, vecs[i].idl);
      chk($sformatf("v%0d_pend1", i), pend1, vecs[i].p1);
      chk($sformatf("v%0d_pend2", i), pend2, vecs[i].p2);
      chk($sformatf("v%0d_fwd1", i), fwd_data1, exp_fwd(vecs[i].f1));
      chk($sformatf("v%0d_fwd2", i), fwd_data2, exp_fwd(vecs[i].f2));
      @(posedge clk); #1;
      chk($sformatf("v%0d_wctrl", i), writeCTRL, vecs[i].wc);
      chk($sformatf("v%0d_wreg", i), writeREG, vecs[i].wr);
      chk($sformatf("v%0d_wdata", i), writeDATA, vecs[i].wd);
    end
    in_valid = 1'b0; wb_stall = 1'b0;
    @(posedge clk); #1;
    chk("rf_r3", rf[3], 8'hA5);
    chk("rf_r1", rf[1], 8'h11);
    chk("rf_r2", rf[2], 8'h22);
    chk("rf_r4_untouched", rf[4], 8'h00);
    chk("rf_r5_youngest", rf[5], 8'h20);

    // Reset in the middle of a drain with two writes pending.
    wb_stall = 1'b1; in_valid = 1'b1; in_reg = 3'd6; in_data = 8'h66;
    @(posedge clk); #1;
    in_reg = 3'd7; in_data = 8'h77;
    @(posedge clk); #1;
    in_valid = 1'b0; wb_stall = 1'b0; rd_addr1 = 3'd7;
    @(posedge clk); #1;
    chk("mid_wctrl_before", writeCTRL, 1);
    chk("mid_wreg_before", writeREG, 6);
    #1 rst = 1'b1;
    #1;
    chk("mid_wctrl_rst", writeCTRL, 0);
    chk("mid_idle_rst", idle, 1);
    chk("mid_ready_rst", in_ready, 1);
    chk("mid_pend_rst", pend1, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("mid_wctrl_after", writeCTRL, 0);
      chk("mid_idle_after", idle, 1);
    end
    chk("mid_rf_r6", rf[6], 8'h00);
    chk("mid_rf_r7", rf[7], 8'h00);

    // Full FIFO then streaming with in_valid held: 16 writes, no gaps, order kept.
    k = 0; w = 0;
    wb_stall = 1'b1; in_valid = 1'b1;
    in_reg = k[2:0]; in_data = item_data(k);
    @(posedge clk); #1;
    k = 1; in_reg = k[2:0]; in_data = item_data(k);
    @(posedge clk); #1;
    k = 2;
    chk("stream_full", in_ready, 0);
    wb_stall = 1'b0;
    for (int c = 0; c < 60 && w < 16; c++) begin
      in_valid = (k < 16); in_reg = k[2:0]; in_data = item_data(k);
      #1;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) k++;
      if (writeCTRL) begin
        chk($sformatf("stream_reg%0d", w), writeREG, w[2:0]);
        chk($sformatf("stream_data%0d", w), writeDATA, item_data(w));
        w++;
      end else begin
        chk("stream_gap", writeCTRL, 1);
      end
    end
    chk("stream_count", w, 16);
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("stream_idle_end", idle, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
